// File: rtl/patternbuf_dbl.sv
// Double-banked pattern buffer: serial frames shift into a shadow bank and are
// committed atomically to the active bank, which the host reads/writes by address.
module patternbuf_dbl #(
  parameter int DEPTH       = 22,
  parameter int WIDTH       = 8,
  parameter int AW          = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             sin,
  input  logic             scs,
  output logic             sout,
  input  logic [AW-1:0]    field_addr,
  output logic [WIDTH-1:0] field_byte,
  input  logic [AW-1:0]    field_wr_addr,
  input  logic [WIDTH-1:0] field_in,
  input  logic             field_write,
  output logic             busy,
  output logic             load_done,
  output logic             frame_err
);
  localparam int NBITS = DEPTH * WIDTH;
  localparam int CW    = $clog2(NBITS + 2);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                       state, state_nxt;
  logic [SYNC_STAGES-1:0]       sclk_q, sin_q, scs_q;
  logic                         sclk_s, sin_s, scs_s, sclk_d, sclk_edge;
  logic                         shift_en, commit, reject, clr;
  logic [CW-1:0]                count;
  logic [NBITS-1:0]             shadow;
  logic [DEPTH-1:0][WIDTH-1:0]  active;
  logic                         wr_ok, rd_ok;

  assign sclk_s    = sclk_q[SYNC_STAGES-1];
  assign sin_s     = sin_q[SYNC_STAGES-1];
  assign scs_s     = scs_q[SYNC_STAGES-1];
  assign sclk_edge = sclk_s & ~sclk_d;
  assign sout      = shadow[NBITS-1];
  assign busy      = (state != IDLE);
  assign wr_ok     = field_write && ({1'b0, field_wr_addr} < (AW+1)'(DEPTH));
  assign rd_ok     = ({1'b0, field_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q <= '0;
      sin_q  <= '0;
      scs_q  <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sin_q  <= {sin_q[SYNC_STAGES-2:0], sin};
      scs_q  <= {scs_q[SYNC_STAGES-2:0], scs};
      sclk_d <= sclk_s;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: if (scs_s) begin
        state_nxt = LOAD;
        clr       = 1'b1;
      end
      LOAD: begin
        if (scs_s) shift_en = sclk_edge;
        else if (count == CW'(NBITS)) state_nxt = COMMIT;
        else begin
          reject    = 1'b1;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      shadow     <= '0;
      active     <= '0;
      field_byte <= '0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      load_done <= commit;
      frame_err <= reject;
      if (clr) count <= '0;
      else if (shift_en && count != CW'(NBITS + 1)) count <= count + 1'b1;
      // One flat shift register: entry i's MSB feeds entry i+1's LSB.
      if (shift_en) shadow <= {shadow[NBITS-2:0], sin_s};
      // Commit is placed after the host write so it wins on a collision.
      if (wr_ok) active[field_wr_addr] <= field_in;
      if (commit) active <= shadow;
      field_byte <= rd_ok ? active[field_addr] : '0;
    end
  end
endmodule

// File: tb/tb_patternbuf_dbl.sv
// Directed bench for patternbuf_dbl: host port, serial frames, commit/reject, reset abort.
module tb_patternbuf_dbl;
  localparam int DEPTH = 22, WIDTH = 8, AW = 5, N = DEPTH * WIDTH;

  logic             clk = 0, reset = 1;
  logic             sclk = 0, sin = 0, scs = 0;
  logic             sout, busy, load_done, frame_err, field_write = 0;
  logic [AW-1:0]    field_addr = '0, field_wr_addr = '0;
  logic [WIDTH-1:0] field_byte, field_in = '0;

  int checks = 0, failures = 0;
  int ld_cnt = 0, err_cnt = 0;
  logic [N-1:0] sh = '0;

  patternbuf_dbl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .sin(sin), .scs(scs), .sout(sout),
    .field_addr(field_addr), .field_byte(field_byte), .field_wr_addr(field_wr_addr),
    .field_in(field_in), .field_write(field_write), .busy(busy),
    .load_done(load_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && load_done) ld_cnt <= ld_cnt + 1;
    if (!reset && frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int a, input logic [7:0] exp, input string tag);
    field_addr = AW'(a);
    @(negedge clk);
    chk(tag, {24'd0, field_byte}, {24'd0, exp});
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    field_wr_addr = AW'(a); field_in = d; field_write = 1;
    @(negedge clk);
    field_write = 0;
  endtask

  // Entry k at bits [k*8 +: 8]; bit N-1 goes out first (entry 21 MSB).
  function automatic logic [N-1:0] mk(input int mode);
    logic [N-1:0] v = '0;
    for (int k = 0; k < DEPTH; k++) begin
      case (mode)
        0: v[k*8 +: 8] = 8'(k + 1);
        1: v[k*8 +: 8] = 8'(8'h80 | k);
        2: v[k*8 +: 8] = 8'(8'h40 + k);
        default: v[k*8 +: 8] = 8'(k ^ 8'hA0);
      endcase
    end
    return v;
  endfunction

  task automatic shift_bit(input logic b);
    sin = b;
    repeat (3) @(negedge clk);
    sclk = 1;
    repeat (4) @(negedge clk);
    sclk = 0;
    repeat (4) @(negedge clk);
    sh = {sh[N-2:0], b};
    chk("sout", {31'd0, sout}, {31'd0, sh[N-1]});
  endtask

  task automatic frame_bits(input logic [N-1:0] v, input int nbits);
    scs = 1;
    repeat (4) @(negedge clk);
    for (int j = 0; j < nbits; j++) shift_bit(j < N ? v[N-1-j] : 1'b1);
  endtask

  task automatic end_frame();
    scs = 0;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_bank(input logic [N-1:0] v, input string tag);
    for (int k = 0; k < DEPTH; k++) rd(k, v[k*8 +: 8], tag);
  endtask

  initial begin
    logic [N-1:0] v0, v1, v2, v3, exp_bank;
    bit seen;
    v0 = mk(0); v1 = mk(1); v2 = mk(2); v3 = mk(3);

    // Reset state
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_load_done", {31'd0, load_done}, 0);
    chk("rst_frame_err", {31'd0, frame_err}, 0);
    chk("rst_sout", {31'd0, sout}, 0);
    chk_bank('0, "rst_bank");

    // Host write/read, out-of-range write ignored and read returns 0
    wr(3, 8'hA5);
    rd(3, 8'hA5, "wr_rd3");
    wr(25, 8'h77);
    exp_bank = '0; exp_bank[3*8 +: 8] = 8'hA5;
    chk_bank(exp_bank, "oob_wr");
    rd(25, 8'h00, "rd_oob");

    // Full frame; addr 3 shows old value on the load_done cycle, new afterwards
    frame_bits(v0, N);
    field_addr = 3;
    scs = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (load_done) seen = 1;
    end
    chk("ld_seen", {31'd0, seen}, 1);
    chk("pre_commit", {24'd0, field_byte}, 32'hA5);
    chk("busy_after", {31'd0, busy}, 0);
    @(negedge clk);
    chk("post_commit", {24'd0, field_byte}, 32'h04);
    repeat (4) @(negedge clk);
    chk("ld_cnt1", ld_cnt, 1);
    chk_bank(v0, "frame1");

    // 8 extra bits of 0xFF shift old shadow MSBs out on sout; short frame rejected
    frame_bits('1, 8);
    end_frame();
    chk("err_short8", err_cnt, 1);

    // Underrun and overrun both rejected, active bank untouched
    frame_bits(v1, N - 1);
    end_frame();
    frame_bits(v1, N + 1);
    end_frame();
    chk("err_cnt3", err_cnt, 3);
    chk("ld_cnt_still1", ld_cnt, 1);
    chk_bank(v0, "after_reject");

    // Write colliding with the commit edge is lost
    frame_bits(v1, N);
    scs = 0;
    repeat (3) @(negedge clk);
    chk("in_commit_busy", {31'd0, busy}, 1);
    chk("in_commit_ld", {31'd0, load_done}, 0);
    wr(0, 8'h3C);
    chk("commit_ld", {31'd0, load_done}, 1);
    repeat (4) @(negedge clk);
    rd(0, 8'h80, "commit_wins");
    rd(1, 8'h81, "commit_e1");

    // Same write one cycle after the commit edge lands
    frame_bits(v2, N);
    scs = 0;
    repeat (4) @(negedge clk);
    wr(0, 8'h3C);
    repeat (4) @(negedge clk);
    rd(0, 8'h3C, "late_wr");
    rd(1, 8'h41, "late_e1");
    chk("ld_cnt3", ld_cnt, 3);
    chk("err_cnt_still3", err_cnt, 3);

    // Reset at bit 90 aborts the frame silently
    frame_bits(v0, 90);
    reset = 1; scs = 0;
    repeat (5) @(negedge clk);
    reset = 0;
    sh = '0;
    repeat (8) @(negedge clk);
    chk("abort_err", err_cnt, 3);
    chk("abort_ld", ld_cnt, 3);
    chk("abort_sout", {31'd0, sout}, 0);
    chk_bank('0, "abort_bank");
    frame_bits(v3, N);
    end_frame();
    chk("frame4_ld", ld_cnt, 4);
    chk("frame4_err", err_cnt, 3);
    chk_bank(v3, "frame4");

    // sclk toggles with scs low leave shadow alone
    chk("sout_pre_tog", {31'd0, sout}, 1);
    for (int i = 0; i < 4; i++) begin
      sin = 1'(i);
      repeat (3) @(negedge clk);
      sclk = 1;
      repeat (4) @(negedge clk);
      sclk = 0;
      repeat (4) @(negedge clk);
      chk("tog_sout", {31'd0, sout}, {31'd0, sh[N-1]});
    end
    chk("tog_busy", {31'd0, busy}, 0);
    chk("tog_err", err_cnt, 3);
    chk_bank(v3, "tog_bank");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
